// File: rtl/fetch_ctrl.sv
// fetch_ctrl: sequences the fetch PC against a handshaked instruction memory.
// It issues one request per accepted PC, tags each in-flight request with its
// PC, and buffers responses in an in-order FIFO for decode. After a redirect,
// responses that are still in flight are drained and discarded.
// Optional build macro: FETCH_CTRL_PERF_EN adds the perf_stall_cycles and
// perf_dropped counters.
module fetch_ctrl #(
  parameter int DEPTH     = 4,
  parameter int MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        mispred,
  output logic        stall,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_dropped
`endif
);

  localparam int FPW = $clog2(DEPTH);
  localparam int CW  = FPW + 1;
  localparam int TPW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int OW  = $clog2(MAX_OUTST + 1);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t         state, state_nxt;

  // outst counts every in-flight request, including those to be dropped
  logic [OW-1:0]  outst, outst_nxt;
  logic [OW-1:0]  drop, drop_nxt;

  logic [CW-1:0]  fifo_count, fifo_count_nxt;
  logic [FPW-1:0] fifo_rd, fifo_wr;
  logic [TPW-1:0] tag_rd, tag_wr;

  logic [31:0]    fifo_inst [DEPTH];
  logic [31:0]    fifo_pc   [DEPTH];
  logic [31:0]    tag_mem   [MAX_OUTST];

  logic           can_req;
  logic           req_fire;
  logic           resp_keep;
  logic           fifo_push;
  logic           fifo_pop;
  logic           fifo_empty;
  logic           fifo_full;

  // The tag queue need not be a power of two, so wrap explicitly
  function automatic logic [TPW-1:0] tag_inc(input logic [TPW-1:0] p);
    if (p == TPW'(MAX_OUTST - 1)) return '0;
    return p + TPW'(1);
  endfunction

  // Credit rule: every outstanding request owns a FIFO slot, so a kept
  // response always finds space
  assign can_req = !mispred
                && (32'(outst) < 32'(MAX_OUTST))
                && ((32'(fifo_count) + 32'(outst)) < 32'(DEPTH));

  assign imem_req_valid = !reset && can_req;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A redirect must let the PC register load commit_pc, so stall drops then
  assign stall = reset || (!req_fire && !mispred);

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CW'(DEPTH));

  assign dec_valid = !fifo_empty && !mispred;
  assign fifo_pop  = dec_valid && dec_ready;

  // Responses are kept only on the correct path; a response in the redirect
  // cycle itself is wrong-path
  assign resp_keep = imem_resp_valid && (state == RUN) && !mispred;
  assign fifo_push = resp_keep;

  // Head data is forced to zero when empty so decode never sees stale words
  assign dec_inst = fifo_empty ? '0 : fifo_inst[fifo_rd];
  assign dec_pc   = fifo_empty ? '0 : fifo_pc[fifo_rd];

  // Next-state for the drain FSM, credit counter and FIFO occupancy
  always_comb begin
    state_nxt      = state;
    drop_nxt       = drop;
    outst_nxt      = outst + OW'(req_fire) - OW'(imem_resp_valid);
    fifo_count_nxt = fifo_count;
    if (mispred) begin
      // Everything still in flight is wrong-path; a beat arriving now is
      // discarded directly and so is not counted again
      drop_nxt       = outst - OW'(imem_resp_valid);
      state_nxt      = (drop_nxt != '0) ? DRAIN : RUN;
      fifo_count_nxt = '0;
    end else begin
      if ((state == DRAIN) && imem_resp_valid) begin
        drop_nxt = drop - OW'(1);
        if (drop_nxt == '0) state_nxt = RUN;
      end
      fifo_count_nxt = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // Counters and queue pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      outst      <= '0;
      drop       <= '0;
      fifo_count <= '0;
      fifo_rd    <= '0;
      fifo_wr    <= '0;
      tag_rd     <= '0;
      tag_wr     <= '0;
    end else begin
      outst      <= outst_nxt;
      drop       <= drop_nxt;
      fifo_count <= fifo_count_nxt;
      if (mispred) begin
        fifo_rd <= '0;
        fifo_wr <= '0;
      end else begin
        if (fifo_push) fifo_wr <= fifo_wr + FPW'(1);
        if (fifo_pop)  fifo_rd <= fifo_rd + FPW'(1);
      end
      // Tags survive a redirect so they stay aligned with in-flight beats
      if (req_fire)        tag_wr <= tag_inc(tag_wr);
      if (imem_resp_valid) tag_rd <= tag_inc(tag_rd);
    end
  end

  // Tag storage: the PC of each accepted request
  always_ff @(posedge clk) begin
    if (req_fire) tag_mem[tag_wr] <= pc;
  end

  // FIFO storage: instruction word paired with its tag PC
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_inst[fifo_wr] <= imem_resp_data;
      fifo_pc[fifo_wr]   <= tag_mem[tag_rd];
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  // Stall-cycle and discarded-response counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cycles <= '0;
      perf_dropped      <= '0;
    end else begin
      if (stall) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (imem_resp_valid && !resp_keep) perf_dropped <= perf_dropped + 32'd1;
    end
  end
`endif

  // The credit rule makes a push into a full FIFO impossible
  assert property (@(posedge clk) disable iff (reset) !(fifo_push && fifo_full));

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized bench for fetch_ctrl with a PC-register model, an
// in-order memory model with random latency, and a transaction-level model of
// what decode must see.
module tb_fetch_ctrl;

  localparam int DEPTH     = 4;
  localparam int MAX_OUTST = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        mispred;
  logic        stall;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_dropped;
`endif

  always #5 clk = ~clk;

  fetch_ctrl #(.DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST)) dut (
    .clk             (clk),
    .reset           (reset),
    .pc              (pc),
    .mispred         (mispred),
    .stall           (stall),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .dec_inst        (dec_inst),
    .dec_pc          (dec_pc)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_dropped      (perf_dropped)
`endif
  );

  // A request the memory has accepted but not yet answered
  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          wrong;
  } pend_t;

  pend_t       pend_q[$];     // in-flight requests, oldest first
  logic [31:0] fifo_pc_q[$];  // correct-path PCs answered but not yet decoded

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          fires = 0;
  bit          prev_rst = 1'b0;
  logic [31:0] pc_nxt = '0;
  logic [31:0] m_stall_cnt = '0;
  logic [31:0] m_drop_cnt = '0;

  int p_ready   = 100;
  int p_dec     = 100;
  int p_mis     = 0;
  int p_resp    = 100;
  int max_extra = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive at negedge, check 1ns later, advance the model
  task automatic cycle(input bit rst_i);
    bit          exp_rv;
    bit          exp_stall;
    bit          exp_dv;
    bit          fire;
    bit          rsp;
    logic [31:0] cpc;
    pend_t       e;
    @(negedge clk);
    cyc++;
    pc      = pc_nxt;
    reset   = rst_i;
    mispred = !rst_i && ($urandom_range(99) < p_mis);
    cpc     = 32'h100 + ($urandom_range(63) << 2);
    imem_req_ready = ($urandom_range(99) < p_ready);
    dec_ready      = ($urandom_range(99) < p_dec);
    rsp = !rst_i && (pend_q.size() > 0) && (pend_q[0].due <= cyc)
          && ($urandom_range(99) < p_resp);
    imem_resp_valid = rsp;
    imem_resp_data  = rsp ? mem_word(pend_q[0].addr) : $urandom;
    #1;
    if (rst_i) begin
      if (prev_rst) begin
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_stall",     32'(stall),          32'd1);
        chk("rst_dec_valid", 32'(dec_valid),      32'd0);
        chk("rst_dec_inst",  dec_inst,            32'd0);
        chk("rst_dec_pc",    dec_pc,              32'd0);
      end
      prev_rst = 1'b1;
      pend_q.delete();
      fifo_pc_q.delete();
      pc_nxt      = '0;
      m_stall_cnt = '0;
      m_drop_cnt  = '0;
      return;
    end
    prev_rst = 1'b0;

    exp_rv    = !mispred && (pend_q.size() < MAX_OUTST)
                && ((fifo_pc_q.size() + pend_q.size()) < DEPTH);
    fire      = exp_rv && imem_req_ready;
    exp_stall = !fire && !mispred;
    exp_dv    = (fifo_pc_q.size() > 0) && !mispred;

    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("req_addr", imem_req_addr, pc);
    chk("stall", 32'(stall), 32'(exp_stall));
    chk("dec_valid", 32'(dec_valid), 32'(exp_dv));
    if (exp_dv) begin
      chk("dec_pc",   dec_pc,   fifo_pc_q[0]);
      chk("dec_inst", dec_inst, mem_word(fifo_pc_q[0]));
    end
`ifdef FETCH_CTRL_PERF_EN
    chk("perf_stall",   perf_stall_cycles, m_stall_cnt);
    chk("perf_dropped", perf_dropped,      m_drop_cnt);
`endif

    // Effect of the coming clock edge
    if (exp_stall) m_stall_cnt++;
    if (mispred) begin
      fifo_pc_q.delete();
      foreach (pend_q[i]) pend_q[i].wrong = 1'b1;
    end else if (exp_dv && dec_ready) begin
      void'(fifo_pc_q.pop_front());
    end
    if (rsp) begin
      e = pend_q.pop_front();
      if (e.wrong) m_drop_cnt++;
      else         fifo_pc_q.push_back(e.addr);
    end
    if (fire) begin
      pend_q.push_back('{addr: pc, due: cyc + 1 + int'($urandom_range(max_extra)), wrong: 1'b0});
      fires++;
    end
    pc_nxt = mispred ? cpc : (fire ? pc + 32'd4 : pc);
  endtask

  task automatic do_reset();
    cycle(1'b1);
    cycle(1'b1);
    cycle(1'b1);
  endtask

  initial begin
    reset           = 1'b1;
    pc              = '0;
    mispred         = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    dec_ready       = 1'b0;

    // Streaming: memory always ready, one-cycle latency, decode always ready
    do_reset();
    p_ready = 100; p_dec = 100; p_mis = 0; p_resp = 100; max_extra = 0;
    repeat (30) cycle(1'b0);

    // Back-pressure from decode: exactly DEPTH requests, then stalled
    do_reset();
    fires = 0;
    p_dec = 0;
    repeat (20) cycle(1'b0);
    chk("fill_reqs", 32'(fires), 32'(DEPTH));
    chk("fill_pc_held", pc_nxt, 32'(DEPTH * 4));
    p_dec = 100;
    repeat (15) cycle(1'b0);

    // Random memory readiness, latency, decode stalls and redirects
    do_reset();
    p_ready = 50; p_dec = 70; p_mis = 8; p_resp = 70; max_extra = 3;
    repeat (3000) cycle(1'b0);

    // Frequent redirects against a fast memory, reset mid-stream included
    p_ready = 85; p_dec = 90; p_mis = 20; p_resp = 100; max_extra = 0;
    repeat (1000) cycle(1'b0);
    do_reset();
    repeat (1000) cycle(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the fetch PC register against a handshaked instruction memory and feeds fetched instructions to decode.
- Issues one imem request per accepted PC and drives `stall` back to the PC register, so the PC advances exactly when a request is accepted.
- Tracks in-flight requests, buffers responses with their PC in an in-order FIFO, and discards wrong-path responses after a misprediction redirect.

Parameters:
- DEPTH, 4: instruction FIFO entries; power of two, >= 2.
- MAX_OUTST, 2: maximum imem requests in flight; >= 1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- pc  in  32  current fetch PC from the PC register.
- mispred  in  1  redirect pulse; the PC register loads commit_pc the same cycle.
- stall  out  1  to the PC register; 0 means the PC advances this cycle.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  32  equals pc.
- imem_resp_valid  in  1  response beat; responses return in request order, at most one per cycle, never in the acceptance cycle.
- imem_resp_data  in  32  instruction word.
- dec_valid  out  1  FIFO head valid.
- dec_ready  in  1  decode pops the head.
- dec_inst  out  32  head instruction.
- dec_pc  out  32  head PC.

Behaviour:
- Reset (synchronous): FIFO empty, tag queue empty, outst=0, drop=0, FSM=RUN.
- Reset output values: dec_valid=0, imem_req_valid=0, stall=1, dec_inst=0, dec_pc=0.
- Request credit: `can_req = !mispred && outst < MAX_OUTST && (fifo_count + outst) < DEPTH`.
  - outst includes responses still to be dropped, so credits are never lost.
- imem_req_valid = can_req (combinational).
- stall = !(imem_req_valid && imem_req_ready) && !mispred.
  - stall is forced 0 in a mispred cycle so the PC register captures commit_pc.
- Accepted request: pc pushed into a MAX_OUTST-entry tag queue; outst increments.
- Response, FSM=RUN: tag popped, {tag, imem_resp_data} pushed into the FIFO; outst decrements.
  - Space is guaranteed by the credit rule; a push into a full FIFO is an assertion failure.
- Response, FSM=DRAIN: tag popped, data discarded, outst and drop decrement. When drop reaches 0, FSM returns to RUN next cycle.
- mispred cycle:
  - FIFO cleared; tag queue entries kept, since tags must stay aligned with in-flight responses.
  - drop <= outst - (imem_resp_valid ? 1 : 0). A response arriving that same cycle is discarded.
  - FSM <= DRAIN if the new drop is > 0, else RUN.
  - A mispred during DRAIN recomputes drop the same way; no accumulation error is allowed.
- Requests may issue during DRAIN. Their responses arrive after all dropped ones and enter the FIFO normally.
- Pop: dec_valid && dec_ready removes the head. Push and pop in the same cycle keep fifo_count unchanged. dec_valid is gated to 0 during a mispred cycle, and a pop in that cycle is ignored.
- FIFO and tag queue: circular pointers, wrap modulo depth.
  - FIFO count width is clog2(DEPTH)+1; empty and full are distinguished by count.
  - dec_inst/dec_pc read the head combinationally; they are don't-care when dec_valid=0.
- Latency: response to dec_valid is 1 cycle (registered FIFO write, no bypass).
- Reset mid-operation: all in-flight state is discarded. The memory system is also reset, so no stale responses follow.

Optional Feature:
- Macro `FETCH_CTRL_PERF_EN`. When defined, adds two outputs:
  - perf_stall_cycles, 32 bits: counts cycles with stall=1 after reset deassertion.
  - perf_dropped, 32 bits: counts discarded responses.
  - Both wrap at 2^32, and both reset to 0.
- When undefined, neither port nor any counter logic exists.

Test Plan:
- Reset, then imem_req_ready=1 with 1-cycle response latency and dec_ready=1:
  - requests at pc 0,4,8,...; stall=0 every cycle after the first request.
  - dec_pc sequence 0,4,8 with matching dec_inst.
- dec_ready=0, DEPTH=4, MAX_OUTST=2:
  - exactly 4 requests issue, then stall=1 and imem_req_valid=0 permanently.
  - FIFO holds pc 0,4,8,12.
  - Raising dec_ready resumes at pc 16.
- imem_req_ready=0 for 5 cycles: stall=1 each cycle and pc held at 0. On ready=1, one request at addr 0.
- Two outstanding, then mispred with commit_pc=0x100 and no response that cycle:
  - FIFO empties and drop=2.
  - The next two responses are discarded.
  - The next request addr is 0x100, and dec_pc=0x100 appears first.
- mispred in the same cycle as a response with outst=2: that response is discarded, drop=1, exactly one further response dropped.
- With FETCH_CTRL_PERF_EN defined, after the previous scenario perf_dropped=2.
